// File: rtl/channel_dump_if.sv
// Bundle of the dump command, capture-RAM read port and UART transmit handshake
// shared between channel_dump (slave) and the surrounding system (master).
interface channel_dump_if;
    logic       dump;
    logic [1:0] ch_sel;
    logic [8:0] start_addr;
    logic [7:0] ram_rd_data1;
    logic [7:0] ram_rd_data2;
    logic [7:0] ram_rd_data3;
    logic [8:0] ram_addr;
    logic       ram_en;
    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done;
    logic       dump_fin;
    logic       busy;

    modport slave (
        input  dump, ch_sel, start_addr, ram_rd_data1, ram_rd_data2, ram_rd_data3, tx_done,
        output ram_addr, ram_en, tx_data, trmt, dump_fin, busy
    );

    modport master (
        output dump, ch_sel, start_addr, ram_rd_data1, ram_rd_data2, ram_rd_data3, tx_done,
        input  ram_addr, ram_en, tx_data, trmt, dump_fin, busy
    );
endinterface

// File: rtl/channel_dump.sv
// Streams the 512 captured samples of one channel, oldest first, to the UART.
// Define CHANNEL_DUMP_HDR_EN to prefix the stream with a header byte 8'hC0 | ch_sel.
module channel_dump (
    input  logic          clk,
    input  logic          rst,
    channel_dump_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, LATCH, XMIT, WAIT, FIN} state_t;

    state_t     state;
    logic [1:0] ch_sel_reg;
    logic [8:0] start_addr_reg;
    logic [9:0] byte_cnt;
    logic [8:0] next_addr;
`ifdef CHANNEL_DUMP_HDR_EN
    logic       hdr_pend;
`endif

    // Address of the byte after the one just acknowledged; 9-bit sum wraps 511 -> 0.
    assign next_addr = start_addr_reg + byte_cnt[8:0] + 9'd1;

    function automatic logic [7:0] sel_byte(input logic [1:0] sel, input logic [7:0] d1,
                                            input logic [7:0] d2, input logic [7:0] d3);
        case (sel)
            2'd0:    return d1;
            2'd1:    return d2;
            2'd2:    return d3;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ch_sel_reg     <= 2'd0;
            start_addr_reg <= 9'd0;
            byte_cnt       <= 10'd0;
            bus.ram_addr   <= 9'h000;
            bus.ram_en     <= 1'b0;
            bus.tx_data    <= 8'h00;
            bus.trmt       <= 1'b0;
            bus.dump_fin   <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef CHANNEL_DUMP_HDR_EN
            hdr_pend       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dump) begin
                        ch_sel_reg     <= bus.ch_sel;
                        start_addr_reg <= bus.start_addr;
                        byte_cnt       <= 10'd0;
                        bus.busy       <= 1'b1;
                        if (bus.ch_sel == 2'd3) begin
                            state        <= FIN;
                            bus.dump_fin <= 1'b1;
                        end else begin
`ifdef CHANNEL_DUMP_HDR_EN
                            hdr_pend    <= 1'b1;
                            bus.tx_data <= 8'hC0 | {6'b0, bus.ch_sel};
                            bus.trmt    <= 1'b1;
                            state       <= XMIT;
`else
                            bus.ram_en   <= 1'b1;
                            bus.ram_addr <= bus.start_addr;
                            state        <= RD;
`endif
                        end
                    end
                end
                RD: begin
                    bus.ram_en <= 1'b0;
                    state      <= LATCH;
                end
                // RAM data for the address issued in RD is on the read bus now.
                LATCH: begin
                    bus.tx_data <= sel_byte(ch_sel_reg, bus.ram_rd_data1,
                                            bus.ram_rd_data2, bus.ram_rd_data3);
                    bus.trmt    <= 1'b1;
                    state       <= XMIT;
                end
                XMIT: begin
                    bus.trmt <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done) begin
`ifdef CHANNEL_DUMP_HDR_EN
                        if (hdr_pend) begin
                            hdr_pend     <= 1'b0;
                            bus.ram_en   <= 1'b1;
                            bus.ram_addr <= start_addr_reg;
                            state        <= RD;
                        end else
`endif
                        begin
                            byte_cnt <= byte_cnt + 10'd1;
                            if (byte_cnt == 10'd511) begin
                                bus.dump_fin <= 1'b1;
                                state        <= FIN;
                            end else begin
                                bus.ram_en   <= 1'b1;
                                bus.ram_addr <= next_addr;
                                state        <= RD;
                            end
                        end
                    end
                end
                FIN: begin
                    bus.dump_fin <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_channel_dump.sv
// Scoreboard bench for channel_dump: stimulus queues expected bytes/addresses,
// a negedge monitor pops and compares on every trmt and ram_en.
module tb_channel_dump;
`ifdef CHANNEL_DUMP_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FIN_BOUND = 8000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    channel_dump_if bus ();

    channel_dump dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem1 [512];
    logic [7:0] mem2 [512];
    logic [7:0] mem3 [512];
    logic [7:0] exp_q  [$];
    logic [8:0] addr_q [$];
    int n_pass = 0;
    int n_total = 0;
    int trmt_cnt = 0;
    int ren_cnt = 0;
    int fin_cnt = 0;

    function automatic logic [7:0] ram_val(input logic [1:0] sel, input logic [8:0] a);
        case (sel)
            2'd0:    return a[7:0] ^ 8'hA5;
            2'd1:    return a[7:0];
            default: return ~a[7:0];
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Capture RAM with one-cycle read latency
    always @(posedge clk) begin
        if (bus.ram_en) begin
            bus.ram_rd_data1 <= mem1[bus.ram_addr];
            bus.ram_rd_data2 <= mem2[bus.ram_addr];
            bus.ram_rd_data3 <= mem3[bus.ram_addr];
        end
    end

    // UART model: byte complete 5 clocks after each trmt
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.trmt === 1'b1) begin
                repeat (5) @(negedge clk);
                bus.tx_done = 1'b1;
                @(negedge clk);
                bus.tx_done = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (bus.trmt === 1'b1) begin
            trmt_cnt++;
            if (exp_q.size() == 0) check("tx_data_unexpected", 16'(bus.tx_data), 16'hFFFF);
            else check("tx_data", 16'(bus.tx_data), 16'(exp_q.pop_front()));
        end
        if (bus.ram_en === 1'b1) begin
            ren_cnt++;
            if (addr_q.size() == 0) check("ram_addr_unexpected", 16'(bus.ram_addr), 16'hFFFF);
            else check("ram_addr", 16'(bus.ram_addr), 16'(addr_q.pop_front()));
        end
        if (bus.dump_fin === 1'b1) fin_cnt++;
    end

    task automatic queue_dump(input logic [1:0] sel, input logic [8:0] sa);
        logic [8:0] a;
        if (HDR != 0) exp_q.push_back(8'hC0 | {6'b0, sel});
        for (int i = 0; i < 512; i++) begin
            a = sa + i[8:0];
            addr_q.push_back(a);
            exp_q.push_back(ram_val(sel, a));
        end
    endtask

    task automatic issue_dump(input logic [1:0] sel, input logic [8:0] sa);
        int lat;
        @(negedge clk);
        bus.ch_sel = sel;
        bus.start_addr = sa;
        bus.dump = 1'b1;
        @(negedge clk);
        bus.dump = 1'b0;
        check("busy_accept", 16'(bus.busy), 16'd1);
        lat = 1;
        while (bus.trmt !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("dump_to_trmt_latency", 16'(lat), (HDR != 0) ? 16'd1 : 16'd3);
    endtask

    task automatic run_dump(input logic [1:0] sel, input logic [8:0] sa, input bit disturb);
        int base_t, base_f, cyc;
        base_t = trmt_cnt;
        base_f = fin_cnt;
        check("queue_empty_start", 16'(exp_q.size()), 16'd0);
        queue_dump(sel, sa);
        issue_dump(sel, sa);
        if (disturb) begin
            repeat (40) @(negedge clk);
            bus.dump = 1'b1;
            bus.ch_sel = sel ^ 2'd1;
            bus.start_addr = sa + 9'h0AA;
            @(negedge clk);
            bus.dump = 1'b0;
        end
        cyc = 0;
        while (bus.dump_fin !== 1'b1 && cyc < FIN_BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check("dump_fin_seen", 16'(cyc < FIN_BOUND), 16'd1);
        @(negedge clk);
        check("dump_fin_one_cycle", 16'(bus.dump_fin), 16'd0);
        check("busy_after_fin", 16'(bus.busy), 16'd0);
        check("byte_count", 16'(trmt_cnt - base_t), 16'(512 + HDR));
        check("fin_count", 16'(fin_cnt - base_f), 16'd1);
        check("tx_queue_drained", 16'(exp_q.size()), 16'd0);
        check("addr_queue_drained", 16'(addr_q.size()), 16'd0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int base_t, base_r, base_f, cyc;
        for (int i = 0; i < 512; i++) begin
            mem1[i] = i[7:0] ^ 8'hA5;
            mem2[i] = i[7:0];
            mem3[i] = ~i[7:0];
        end
        rst = 1'b1;
        bus.dump = 1'b0;
        bus.ch_sel = 2'd0;
        bus.start_addr = 9'd0;
        repeat (3) @(negedge clk);
        check("rst_ram_en", 16'(bus.ram_en), 16'd0);
        check("rst_trmt", 16'(bus.trmt), 16'd0);
        check("rst_dump_fin", 16'(bus.dump_fin), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_tx_data", 16'(bus.tx_data), 16'h00);
        check("rst_ram_addr", 16'(bus.ram_addr), 16'h000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CH2, start 0: bytes 00..FF twice
        run_dump(2'd1, 9'h000, 1'b0);
        // CH1, start 1F0: address wraps 1FF -> 000
        run_dump(2'd0, 9'h1F0, 1'b0);
        // CH3 with a second dump and ch_sel/start_addr change mid-dump
        run_dump(2'd2, 9'h055, 1'b1);

        // Invalid channel: immediate finish, no reads, no transmit
        base_t = trmt_cnt;
        base_r = ren_cnt;
        @(negedge clk);
        bus.ch_sel = 2'd3;
        bus.start_addr = 9'h123;
        bus.dump = 1'b1;
        @(negedge clk);
        bus.dump = 1'b0;
        check("sel3_fin_n1", 16'(bus.dump_fin), 16'd1);
        check("sel3_busy_n1", 16'(bus.busy), 16'd1);
        @(negedge clk);
        check("sel3_fin_n2", 16'(bus.dump_fin), 16'd0);
        check("sel3_busy_n2", 16'(bus.busy), 16'd0);
        repeat (8) @(negedge clk);
        check("sel3_no_trmt", 16'(trmt_cnt - base_t), 16'd0);
        check("sel3_no_ram_en", 16'(ren_cnt - base_r), 16'd0);

        // Reset after byte 100 abandons the dump
        base_t = trmt_cnt;
        base_f = fin_cnt;
        queue_dump(2'd2, 9'h100);
        issue_dump(2'd2, 9'h100);
        cyc = 0;
        while (trmt_cnt - base_t < 100 && cyc < FIN_BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_byte_100", 16'(cyc < FIN_BOUND), 16'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_ram_en", 16'(bus.ram_en), 16'd0);
        check("midrst_trmt", 16'(bus.trmt), 16'd0);
        check("midrst_dump_fin", 16'(bus.dump_fin), 16'd0);
        check("midrst_busy", 16'(bus.busy), 16'd0);
        check("midrst_tx_data", 16'(bus.tx_data), 16'h00);
        check("midrst_ram_addr", 16'(bus.ram_addr), 16'h000);
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_no_fin", 16'(fin_cnt - base_f), 16'd0);
        run_dump(2'd2, 9'h100, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/channel_dump.md
CHANNEL_DUMP -- requirements
Module: channel_dump

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port dump  input  1  single-cycle dump request from the command layer.
REQ-004 SHALL have port ch_sel  input  2  channel to dump: 0=CH1, 1=CH2, 2=CH3, 3=invalid.
REQ-005 SHALL have port start_addr  input  9  oldest-sample address, the capture block's addr_ptr after capture done.
REQ-006 SHALL have ports ram_rd_data1 / ram_rd_data2 / ram_rd_data3  input  8 each  capture RAM read data; 1-cycle read latency after ram_en.
REQ-007 SHALL have port ram_addr  output  9  shared capture RAM read address.
REQ-008 SHALL have port ram_en  output  1  RAM read enable; RAM write enable is never driven by this block.
REQ-009 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-010 SHALL have port trmt  output  1  one-cycle UART transmit strobe.
REQ-011 SHALL have port tx_done  input  1  UART byte-complete indication.
REQ-012 SHALL have port dump_fin  output  1  one-cycle pulse when the dump completes; feeds the capture block's dump_fin.
REQ-013 SHALL have port busy  output  1  high from request accept until dump_fin.

Function
REQ-014 SHALL implement states IDLE, RD, LATCH, XMIT, WAIT, FIN.
- IDLE -> RD on dump.
- RD -> LATCH.
- LATCH -> XMIT.
- XMIT -> WAIT.
- WAIT -> RD on tx_done with bytes remaining.
- WAIT -> FIN on tx_done for the last byte.
- FIN -> IDLE.
REQ-015 SHALL register ch_sel and start_addr when dump is accepted in IDLE; later changes SHALL have no effect on the dump in progress.
REQ-016 SHALL ignore dump in any state other than IDLE.
REQ-017 SHALL, in RD, drive ram_en=1 and ram_addr = start_addr_reg + byte_cnt, modulo 512.
- The address wraps 511 -> 0.
- ram_en SHALL be 0 in all other states.
REQ-018 SHALL, in LATCH, load tx_data from the read-data bus selected by the registered ch_sel.
REQ-019 SHALL assert trmt only in XMIT, for exactly one cycle per byte.
REQ-020 SHALL hold tx_data stable from LATCH until the following tx_done.
REQ-021 SHALL accept tx_done only in WAIT; tx_done in any other state SHALL be ignored.
REQ-022 SHALL use a 10-bit byte_cnt, cleared on accept and incremented on each accepted tx_done; the dump is complete after 512 data bytes.
REQ-023 SHALL give a latency of 3 clocks from dump (cycle N) to trmt (cycle N+3): RD at N+1, LATCH at N+2, XMIT at N+3.
REQ-024 SHALL assert dump_fin high for exactly one cycle in FIN.
REQ-025 SHALL handle registered ch_sel=3 as follows: IDLE -> FIN directly, no RAM read, no trmt, dump_fin one cycle after the request.
REQ-026 SHALL assert busy in every state except IDLE.

Reset
REQ-027 SHALL on rst, immediately and asynchronously:
- force state to IDLE;
- drive ram_en=0, trmt=0, dump_fin=0, busy=0;
- drive tx_data=8'h00, ram_addr=9'h000;
- clear byte_cnt.
REQ-028 SHALL, when reset arrives mid-dump, abandon the dump with no dump_fin; a new dump after reset release SHALL start from byte 0.

Configuration
REQ-029 SHALL support the macro CHANNEL_DUMP_HDR_EN.
- Defined: before the first data byte, transmit one header byte 8'hC0 | {6'b0, ch_sel_reg} using the same XMIT/WAIT handshake, with no RAM read. Total is 513 bytes, and dump -> first trmt latency becomes 1 clock.
- Undefined: no header; behaviour exactly as REQ-014..REQ-026.

Verification
REQ-030 SHALL cover: ch_sel=1, start_addr=0, RAM2[i]=i[7:0], tx_done 5 clocks after each trmt -> 512 trmt pulses, tx_data 00..FF twice, one dump_fin, busy low afterwards.
REQ-031 SHALL cover: start_addr=9'h1F0, ch_sel=0 -> ram_addr sequence 1F0..1FF, 000..1EF; 512 bytes; dump_fin once.
REQ-032 SHALL cover: second dump pulse and ch_sel change mid-dump -> ignored; output stream and count unchanged.
REQ-033 SHALL cover: ch_sel=3 -> dump_fin at N+1, no trmt, no ram_en.
REQ-034 SHALL cover: rst asserted after byte 100 -> all outputs at reset values at once, no dump_fin; a new dump then sends 512 bytes from start_addr.
REQ-035 SHALL cover: with CHANNEL_DUMP_HDR_EN defined, ch_sel=2 -> first byte 8'hC2, then 512 data bytes, then dump_fin.
